// File: rtl/instr_fetch.sv
`default_nettype none
// instr_fetch: fetches an opcode and its optional immediate byte from program memory,
// presents the instruction to decode, and applies taken-branch PC redirects.
module instr_fetch #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter logic [3:0] OP_CPY   = 4'h2,
   parameter logic [3:0] OP_JEQ   = 4'hC,
   parameter logic [3:0] OP_JMP   = 4'hD
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] imem_addr,
   output logic       imem_req,
   input  logic       imem_ack,
   input  logic [7:0] imem_rdata,
   output logic [7:0] instr,
   output logic [7:0] imm,
   output logic       has_imm,
   output logic [7:0] instr_pc,
   output logic       out_valid,
   input  logic       out_ready,
   input  logic       branch_en,
   input  logic [7:0] branch_target
);

   typedef enum logic [1:0] {
      FETCH_OP  = 2'd0,
      FETCH_IMM = 2'd1,
      VALID     = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] pc;
   logic       needs_imm;

   // CPY carries an immediate only in its rd == rs form.
   assign needs_imm = (imem_rdata[7:4] == OP_JEQ) ||
                      (imem_rdata[7:4] == OP_JMP) ||
                      ((imem_rdata[7:4] == OP_CPY) && (imem_rdata[3:2] == imem_rdata[1:0]));

   assign imem_addr = pc;
   assign imem_req  = rst_n && (state != VALID);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         state     <= FETCH_OP;
         out_valid <= 1'b0;
         instr     <= 8'h00;
         imm       <= 8'h00;
         has_imm   <= 1'b0;
         instr_pc  <= 8'h00;
      end else if (branch_en) begin
         // Redirect wins over any ack or handshake in the same cycle.
         pc        <= branch_target;
         state     <= FETCH_OP;
         out_valid <= 1'b0;
         has_imm   <= 1'b0;
      end else begin
         case (state)
            FETCH_OP: begin
               if (imem_ack) begin
                  instr    <= imem_rdata;
                  instr_pc <= pc;
                  pc       <= pc + 8'd1;
                  has_imm  <= needs_imm;
                  imm      <= 8'h00;
                  if (needs_imm) begin
                     state <= FETCH_IMM;
                  end else begin
                     state     <= VALID;
                     out_valid <= 1'b1;
                  end
               end
            end
            FETCH_IMM: begin
               if (imem_ack) begin
                  imm       <= imem_rdata;
                  pc        <= pc + 8'd1;
                  state     <= VALID;
                  out_valid <= 1'b1;
               end
            end
            VALID: begin
               if (out_ready) begin
                  state     <= FETCH_OP;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= FETCH_OP;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// Directed bench for instr_fetch with a behavioural program memory whose ack can be stalled.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] imem_addr;
   logic       imem_req;
   logic       imem_ack;
   logic [7:0] imem_rdata;
   logic [7:0] instr;
   logic [7:0] imm;
   logic       has_imm;
   logic [7:0] instr_pc;
   logic       out_valid;
   logic       out_ready;
   logic       branch_en;
   logic [7:0] branch_target;

   logic [7:0] mem [256];
   logic       ack_en;
   int         total = 0;
   int         passed = 0;

   always #5 clk = ~clk;

   assign imem_ack   = imem_req && ack_en;
   assign imem_rdata = mem[imem_addr];

   instr_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_addr     (imem_addr),
      .imem_req      (imem_req),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .imm           (imm),
      .has_imm       (has_imm),
      .instr_pc      (instr_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .branch_en     (branch_en),
      .branch_target (branch_target)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      branch_en = 1'b0;
      branch_target = 8'h00;
      ack_en = 1'b1;
      clear_mem();

      // Reset state
      tick();
      tick();
      chk("rst_req",     {7'd0, imem_req},  8'h00);
      chk("rst_valid",   {7'd0, out_valid}, 8'h00);
      chk("rst_instr",   instr,             8'h00);
      chk("rst_imm",     imm,               8'h00);
      chk("rst_has_imm", {7'd0, has_imm},   8'h00);
      chk("rst_instr_pc", instr_pc,         8'h00);
      chk("rst_pc",      imem_addr,         8'h00);

      // Two 1-byte instructions, zero-wait memory
      mem[8'h00] = 8'h10;
      mem[8'h01] = 8'h34;
      out_ready = 1'b1;
      rst_n = 1'b1;
      tick();
      chk("t1_valid0",   {7'd0, out_valid}, 8'h01);
      chk("t1_instr0",   instr,             8'h10);
      chk("t1_pc0",      instr_pc,          8'h00);
      chk("t1_has_imm0", {7'd0, has_imm},   8'h00);
      tick();
      chk("t1_gap_valid", {7'd0, out_valid}, 8'h00);
      chk("t1_gap_addr",  imem_addr,         8'h01);
      tick();
      chk("t1_valid1",   {7'd0, out_valid}, 8'h01);
      chk("t1_instr1",   instr,             8'h34);
      chk("t1_pc1",      instr_pc,          8'h01);
      chk("t1_next_pc",  imem_addr,         8'h02);
      chk("t1_req_lo",   {7'd0, imem_req},  8'h00);

      // CPY rd==rs carries an immediate
      clear_mem();
      mem[8'h00] = 8'h25;
      mem[8'h01] = 8'hA7;
      out_ready = 1'b0;
      do_reset();
      tick();
      chk("t2_wait_valid", {7'd0, out_valid}, 8'h00);
      chk("t2_imm_addr",   imem_addr,         8'h01);
      tick();
      chk("t2_valid",   {7'd0, out_valid}, 8'h01);
      chk("t2_instr",   instr,             8'h25);
      chk("t2_has_imm", {7'd0, has_imm},   8'h01);
      chk("t2_imm",     imm,               8'hA7);
      chk("t2_pc",      imem_addr,         8'h02);

      // CPY rd!=rs is a single byte; then hold out_ready low
      clear_mem();
      mem[8'h00] = 8'h24;
      do_reset();
      tick();
      chk("t3_valid",   {7'd0, out_valid}, 8'h01);
      chk("t3_has_imm", {7'd0, has_imm},   8'h00);
      chk("t3_imm",     imm,               8'h00);
      chk("t3_pc",      imem_addr,         8'h01);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_stall_valid", {7'd0, out_valid}, 8'h01);
         chk("t3_stall_instr", instr,             8'h24);
         chk("t3_stall_req",   {7'd0, imem_req},  8'h00);
         chk("t3_stall_pc",    imem_addr,         8'h01);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t3_rel_valid", {7'd0, out_valid}, 8'h00);
      chk("t3_rel_req",   {7'd0, imem_req},  8'h01);
      chk("t3_rel_addr",  imem_addr,         8'h01);

      // Ack delayed 3 cycles; data only taken in the ack cycle
      clear_mem();
      ack_en = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         mem[8'h00] = 8'h50 + 8'(i);
         tick();
         chk("t4_wait_req",   {7'd0, imem_req},  8'h01);
         chk("t4_wait_addr",  imem_addr,         8'h00);
         chk("t4_wait_valid", {7'd0, out_valid}, 8'h00);
      end
      mem[8'h00] = 8'h3C;
      ack_en = 1'b1;
      tick();
      chk("t4_valid", {7'd0, out_valid}, 8'h01);
      chk("t4_instr", instr,             8'h3C);
      chk("t4_pc",    imem_addr,         8'h01);

      // Branch to 0xFF, JMP whose immediate wraps to 0x00
      mem[8'hFF] = 8'hD0;
      mem[8'h00] = 8'h40;
      branch_en = 1'b1;
      branch_target = 8'hFF;
      tick();
      branch_en = 1'b0;
      chk("t5_br_valid", {7'd0, out_valid}, 8'h00);
      chk("t5_br_addr",  imem_addr,         8'hFF);
      chk("t5_br_req",   {7'd0, imem_req},  8'h01);
      tick();
      chk("t5_wrap_addr", imem_addr, 8'h00);
      tick();
      chk("t5_valid",    {7'd0, out_valid}, 8'h01);
      chk("t5_instr",    instr,             8'hD0);
      chk("t5_imm",      imm,               8'h40);
      chk("t5_instr_pc", instr_pc,          8'hFF);
      chk("t5_has_imm",  {7'd0, has_imm},   8'h01);
      chk("t5_pc",       imem_addr,         8'h01);
      branch_en = 1'b1;
      branch_target = 8'h40;
      tick();
      branch_en = 1'b0;
      chk("t5_br2_valid",   {7'd0, out_valid}, 8'h00);
      chk("t5_br2_addr",    imem_addr,         8'h40);
      chk("t5_br2_has_imm", {7'd0, has_imm},   8'h00);

      // Branch coincident with the immediate ack: immediate discarded
      mem[8'h40] = 8'hC0;
      mem[8'h41] = 8'h55;
      mem[8'h80] = 8'h10;
      tick();
      chk("t6_imm_addr", imem_addr, 8'h41);
      branch_en = 1'b1;
      branch_target = 8'h80;
      tick();
      branch_en = 1'b0;
      chk("t6_valid",   {7'd0, out_valid}, 8'h00);
      chk("t6_addr",    imem_addr,         8'h80);
      chk("t6_has_imm", {7'd0, has_imm},   8'h00);
      chk("t6_imm",     imm,               8'h00);
      tick();
      chk("t6_tgt_valid", {7'd0, out_valid}, 8'h01);
      chk("t6_tgt_instr", instr,             8'h10);
      chk("t6_tgt_pc",    instr_pc,          8'h80);

      // Reset mid-fetch with a branch request that must be ignored
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t7_fetch_addr", imem_addr, 8'h81);
      rst_n = 1'b0;
      branch_en = 1'b1;
      branch_target = 8'h33;
      tick();
      chk("t7_addr",     imem_addr,         8'h00);
      chk("t7_req",      {7'd0, imem_req},  8'h00);
      chk("t7_valid",    {7'd0, out_valid}, 8'h00);
      chk("t7_instr",    instr,             8'h00);
      chk("t7_instr_pc", instr_pc,          8'h00);
      chk("t7_has_imm",  {7'd0, has_imm},   8'h00);
      chk("t7_imm",      imm,               8'h00);
      branch_en = 1'b0;
      rst_n = 1'b1;
      mem[8'h00] = 8'h11;
      tick();
      chk("t7_post_valid", {7'd0, out_valid}, 8'h01);
      chk("t7_post_instr", instr,             8'h11);
      chk("t7_post_pc",    instr_pc,          8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
